// File: rtl/serdes_shift.sv
// rtl/serdes_shift.sv - parametrised serializer/deserializer shift register
// One word in via valid/ready, WIDTH bits out/in serially, received word pulsed on out_valid.
module serdes_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             en,
    input  logic             sin,
    output logic             sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] shifted;
    logic             dir_q, dir_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Received bits enter at the end opposite to the one being transmitted,
    // so after WIDTH shifts each bit sits where its transmitted twin started.
    always_comb begin
        shifted     = dir_q ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
        state_d     = state_q;
        sr_d        = sr_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    dir_d   = msb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    sr_d = shifted;
                    if (cnt_q == LAST) begin
                        out_data_d  = shifted;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign sout_valid = (state_q == SHIFT);
    assign sout       = sout_valid & (dir_q ? sr_q[WIDTH-1] : sr_q[0]);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_serdes_shift.sv
// tb/tb_serdes_shift.sv - self-checking bench for serdes_shift
// Bit-index reference model plus directed literal expectations and random traffic.
module tb_serdes_shift;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         msb_first = 1'b0;
    logic         en = 1'b0;
    logic         sin = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, sout, sout_valid, out_valid;
    logic [W-1:0] out_data;

    serdes_shift #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .msb_first  (msb_first),
        .en         (en),
        .sin        (sin),
        .sout       (sout),
        .sout_valid (sout_valid),
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a frame is the word, its order and how many bits have moved.
    bit           m_busy;
    bit           m_msb;
    int           m_k;
    logic [W-1:0] m_word, m_rx, m_out_data;
    bit           m_out_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_sout();
        if (!m_busy) return 1'b0;
        return m_word[m_msb ? W - 1 - m_k : m_k];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_msb = 0; m_k = 0;
        m_word = '0; m_rx = '0; m_out_data = '0; m_out_valid = 0;
    endtask

    task automatic model_step();
        m_out_valid = 0;
        if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_word = in_data; m_msb = msb_first; m_k = 0; m_rx = '0;
            end
        end else if (en) begin
            m_rx[m_msb ? W - 1 - m_k : m_k] = sin;
            m_k++;
            if (m_k == W) begin
                m_out_data  = m_rx;
                m_out_valid = 1;
                m_busy      = 0;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready",   32'(in_ready),   32'(!m_busy));
        chk("sout_valid", 32'(sout_valid), 32'(m_busy));
        chk("sout",       32'(sout),       32'(m_sout()));
        chk("out_valid",  32'(out_valid),  32'(m_out_valid));
        chk("out_data",   32'(out_data),   32'(m_out_data));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare();
    endtask

    // Offer one word, then shift with an optional stall; c counts edges after accept.
    task automatic run_frame(input logic [W-1:0] w, input logic msb, input logic loop,
                             input int stall_at, input int stall_len,
                             output logic [W-1:0] seq, output int lat,
                             output logic [W-1:0] got, output logic stall_hold);
        int shifts = 0;
        int stalled = 0;
        lat = -1; got = '0; seq = '0; stall_hold = 1'b1;
        in_data = w; msb_first = msb; in_valid = 1'b1; en = 1'b1; sin = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                lat = c; got = out_data;
                break;
            end
            if (shifts == stall_at && stalled < stall_len) begin
                en = 1'b0; stalled++; stall_hold &= sout;
            end else begin
                en = 1'b1;
                if (shifts < W) seq[shifts] = sout;
                shifts++;
            end
            sin = loop ? sout : 1'b0;
            tick();
        end
        en = 1'b1; sin = 1'b0;
    endtask

    logic [W-1:0] seq, got, d1, d2;
    logic         hold;
    int           lat, p1, p2;

    initial begin
        model_reset();
        // Reset values, asynchronously before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sout", 32'(sout), 32'h0);
        chk("rst_sout_valid", 32'(sout_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // LSB-first transmit with sin=0
        run_frame(8'hA5, 1'b0, 1'b0, -1, 0, seq, lat, got, hold);
        chk("lsb_seq", 32'(seq), 32'hA5);
        chk("lsb_lat", 32'(lat), 32'd8);
        chk("lsb_data", 32'(got), 32'h00);
        tick();
        chk("lsb_pulse_one_cycle", 32'(out_valid), 32'h0);

        // MSB-first loopback
        run_frame(8'h3C, 1'b1, 1'b1, -1, 0, seq, lat, got, hold);
        chk("msb_seq", 32'(seq), 32'h3C);
        chk("msb_lat", 32'(lat), 32'd8);
        chk("msb_data", 32'(got), 32'h3C);
        tick();
        chk("msb_pulse_one_cycle", 32'(out_valid), 32'h0);

        // Stall for 3 cycles after the 4th shift
        run_frame(8'hF0, 1'b0, 1'b1, 4, 3, seq, lat, got, hold);
        chk("stall_hold", 32'(hold), 32'h1);
        chk("stall_lat", 32'(lat), 32'd11);
        chk("stall_data", 32'(got), 32'hF0);
        tick();

        // Back-to-back with in_valid held; mid-frame offers ignored
        in_valid = 1'b1; in_data = 8'h01; msb_first = 1'b0; en = 1'b1; sin = 1'b0;
        tick();
        p1 = -1; p2 = -1; d1 = '0; d2 = '0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                if (p1 < 0) begin p1 = c; d1 = out_data; end
                else if (p2 < 0) begin p2 = c; d2 = out_data; end
            end
            in_data  = (c < 7) ? 8'hFF : 8'h80;
            in_valid = (c < 9);
            sin      = sout;
            tick();
        end
        chk("b2b_first_lat", 32'(p1), 32'd8);
        chk("b2b_spacing", 32'(p2 - p1), 32'd9);
        chk("b2b_first_data", 32'(d1), 32'h01);
        chk("b2b_second_data", 32'(d2), 32'h80);

        // Reset mid-frame after the 4th shift
        in_valid = 1'b1; in_data = 8'hC3; msb_first = 1'b1; en = 1'b1; sin = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_sout_valid", 32'(sout_valid), 32'h0);
        chk("abort_out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        compare();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_pulse", 32'(out_valid), 32'h0);
        end
        run_frame(8'h5A, 1'b0, 1'b1, -1, 0, seq, lat, got, hold);
        chk("after_abort_lat", 32'(lat), 32'd8);
        chk("after_abort_data", 32'(got), 32'h5A);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            msb_first = 1'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            sin       = ($urandom_range(0, 1) != 0) ? sout : 1'($urandom);
            reset     = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
